// File: rtl/zsram_array.sv
// Multi-word zero-second RAM: strobe edge detection, post-reset clear sweep,
// written-word tracking and registered read data with a valid pulse.
module zsram_array #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              Crystal50Mhz,
  input  logic              ResetLow,
  input  logic              WriteEdge,
  input  logic [ADDR_W-1:0] WriteAddress,
  input  logic [WIDTH-1:0]  inputData,
  input  logic              ReadEdge,
  input  logic [ADDR_W-1:0] ReadAddress,
  output logic [WIDTH-1:0]  outputData,
  output logic              ReadValid,
  output logic              ReadHit,
  output logic              Busy
);

  localparam int unsigned       IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e             r_state, w_state_next;
  logic [IDX_W-1:0]   r_clr_cnt, w_clr_cnt_next;
  logic               r_wr_prev, r_rd_prev;
  logic [DEPTH-1:0]   r_written, w_written_next;
  logic [WIDTH-1:0]   r_out_data, w_out_data_next;
  logic               r_read_valid, w_read_valid_next;
  logic               r_read_hit, w_read_hit_next;
  logic               r_busy;
  logic [WIDTH-1:0]   r_mem [DEPTH];

  logic               w_wr_edge, w_rd_edge;
  logic               w_wr_in_range, w_rd_in_range, w_bypass;
  logic [IDX_W-1:0]   w_wr_idx, w_rd_idx;
  logic               w_mem_we;
  logic [IDX_W-1:0]   w_mem_idx;
  logic [WIDTH-1:0]   w_mem_wdata;

  assign w_wr_edge     = WriteEdge & ~r_wr_prev;
  assign w_rd_edge     = ReadEdge & ~r_rd_prev;
  assign w_wr_in_range = ({1'b0, WriteAddress} < DEPTH_EXT);
  assign w_rd_in_range = ({1'b0, ReadAddress} < DEPTH_EXT);
  assign w_wr_idx      = WriteAddress[IDX_W-1:0];
  assign w_rd_idx      = ReadAddress[IDX_W-1:0];
  // Same-address collision returns the incoming data (write-first)
  assign w_bypass      = w_wr_edge & w_wr_in_range & w_rd_in_range &
                         (WriteAddress == ReadAddress);

  always_comb begin
    w_state_next      = r_state;
    w_clr_cnt_next    = r_clr_cnt;
    w_written_next    = r_written;
    w_out_data_next   = r_out_data;
    w_read_hit_next   = r_read_hit;
    w_read_valid_next = 1'b0;
    w_mem_we          = 1'b0;
    w_mem_idx         = w_wr_idx;
    w_mem_wdata       = inputData;
    unique case (r_state)
      StClear: begin
        w_mem_we    = 1'b1;
        w_mem_idx   = r_clr_cnt;
        w_mem_wdata = '0;
        if (r_clr_cnt == LAST_IDX) begin
          w_state_next = StIdle;
        end else begin
          w_clr_cnt_next = r_clr_cnt + 1'b1;
        end
      end
      StIdle: begin
        if (w_wr_edge && w_wr_in_range) begin
          w_mem_we                 = 1'b1;
          w_written_next[w_wr_idx] = 1'b1;
        end
        if (w_rd_edge) begin
          w_read_valid_next = 1'b1;
          if (w_bypass) begin
            w_out_data_next = inputData;
            w_read_hit_next = 1'b1;
          end else if (w_rd_in_range && r_written[w_rd_idx]) begin
            w_out_data_next = r_mem[w_rd_idx];
            w_read_hit_next = 1'b1;
          end else begin
            w_out_data_next = '0;
            w_read_hit_next = 1'b0;
          end
        end
      end
      default: w_state_next = StClear;
    endcase
    if (!ResetLow) begin
      w_mem_we = 1'b0;
    end
  end

  always_ff @(posedge Crystal50Mhz) begin
    if (!ResetLow) begin
      r_state      <= StClear;
      r_clr_cnt    <= '0;
      r_wr_prev    <= 1'b1;
      r_rd_prev    <= 1'b1;
      r_written    <= '0;
      r_out_data   <= '0;
      r_read_valid <= 1'b0;
      r_read_hit   <= 1'b0;
      r_busy       <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_clr_cnt    <= w_clr_cnt_next;
      r_wr_prev    <= WriteEdge;
      r_rd_prev    <= ReadEdge;
      r_written    <= w_written_next;
      r_out_data   <= w_out_data_next;
      r_read_valid <= w_read_valid_next;
      r_read_hit   <= w_read_hit_next;
      r_busy       <= (w_state_next == StClear);
    end
  end

  // Storage has no reset; the clear sweep zeroes it
  always_ff @(posedge Crystal50Mhz) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wdata;
    end
  end

  assign outputData = r_out_data;
  assign ReadValid  = r_read_valid;
  assign ReadHit    = r_read_hit;
  assign Busy       = r_busy;

endmodule

// File: tb/tb_zsram_array.sv
// Bench for zsram_array: directed test-plan checks plus random strobes
// compared every cycle against an array-based reference model.
module tb_zsram_array;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_stb, rd_stb;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [WIDTH-1:0]  out_data;
  logic              rd_valid, rd_hit, busy;

  int n_checks = 0;
  int n_fail   = 0;

  zsram_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_dut (
    .Crystal50Mhz(clk),
    .ResetLow    (rst_n),
    .WriteEdge   (wr_stb),
    .WriteAddress(wr_addr),
    .inputData   (wr_data),
    .ReadEdge    (rd_stb),
    .ReadAddress (rd_addr),
    .outputData  (out_data),
    .ReadValid   (rd_valid),
    .ReadHit     (rd_hit),
    .Busy        (busy)
  );

  always #10 clk = ~clk;

  // Reference model: word array, written flags, remaining clear cycles
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_wr  [DEPTH];
  int               m_clear_left = 0;
  bit               m_prev_w = 1'b1, m_prev_r = 1'b1;
  logic [WIDTH-1:0] m_out;
  bit               m_valid, m_hit, m_busy;

  always @(posedge clk) begin
    bit we, re;
    if (!rst_n) begin
      m_clear_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
      m_out = '0; m_valid = 1'b0; m_hit = 1'b0; m_busy = 1'b1;
      m_prev_w = 1'b1; m_prev_r = 1'b1;
    end else begin
      we = wr_stb && !m_prev_w;
      re = rd_stb && !m_prev_r;
      m_prev_w = wr_stb;
      m_prev_r = rd_stb;
      m_valid  = 1'b0;
      if (m_clear_left > 0) begin
        m_clear_left--;
      end else begin
        if (re) begin
          m_valid = 1'b1;
          if (rd_addr < DEPTH && we && wr_addr == rd_addr) begin
            m_out = wr_data; m_hit = 1'b1;
          end else if (rd_addr < DEPTH && m_wr[rd_addr]) begin
            m_out = m_mem[rd_addr]; m_hit = 1'b1;
          end else begin
            m_out = '0; m_hit = 1'b0;
          end
        end
        if (we && wr_addr < DEPTH) begin
          m_mem[wr_addr] = wr_data;
          m_wr[wr_addr]  = 1'b1;
        end
      end
      m_busy = (m_clear_left > 0);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock; outputs compared against the model at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_eq("model_data",  32'(out_data), 32'(m_out));
    check_eq("model_valid", 32'(rd_valid), 32'(m_valid));
    check_eq("model_hit",   32'(rd_hit),   32'(m_hit));
    check_eq("model_busy",  32'(busy),     32'(m_busy));
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    wr_addr = a; wr_data = d; wr_stb = 1'b1;
    tick();
    wr_stb = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [WIDTH-1:0] d,
                         output logic v, output logic h);
    rd_addr = a; rd_stb = 1'b1;
    tick();
    d = out_data; v = rd_valid; h = rd_hit;
    rd_stb = 1'b0;
    tick();
  endtask

  logic [WIDTH-1:0] rdata;
  logic             rv, rh;
  int               n_busy;

  initial begin
    rst_n = 1'b0;
    rd_stb = 1'b0; rd_addr = '0;
    // Write strobe held high through reset release must not write
    wr_stb = 1'b1; wr_addr = 5'd2; wr_data = 8'h77;
    tick();
    tick();
    check_eq("reset_busy",  32'(busy),     32'd1);
    check_eq("reset_valid", 32'(rd_valid), 32'd0);
    check_eq("reset_data",  32'(out_data), 32'd0);
    rst_n = 1'b1;

    n_busy = 0;
    while (busy && n_busy < 40) begin
      n_busy++;
      check_eq("clear_valid", 32'(rd_valid), 32'd0);
      tick();
    end
    check_eq("clear_len", 32'(n_busy), 32'd16);
    wr_stb = 1'b0;
    tick();

    do_read(5'd3, rdata, rv, rh);
    check_eq("rd3_valid", 32'(rv), 32'd1);
    check_eq("rd3_hit",   32'(rh), 32'd0);
    check_eq("rd3_data",  32'(rdata), 32'd0);
    do_read(5'd2, rdata, rv, rh);
    check_eq("held_rst_hit", 32'(rh), 32'd0);

    do_write(5'd7, 8'hA5);
    do_read(5'd7, rdata, rv, rh);
    check_eq("rd7_valid", 32'(rv), 32'd1);
    check_eq("rd7_data",  32'(rdata), 32'hA5);
    check_eq("rd7_hit",   32'(rh), 32'd1);
    check_eq("rd7_pulse", 32'(rd_valid), 32'd0);
    check_eq("rd7_hold",  32'(out_data), 32'hA5);

    do_write(5'd5, 8'h11);
    wr_addr = 5'd5; rd_addr = 5'd5; wr_data = 8'h3C;
    wr_stb = 1'b1; rd_stb = 1'b1;
    tick();
    check_eq("bypass_data", 32'(out_data), 32'h3C);
    check_eq("bypass_hit",  32'(rd_hit),   32'd1);
    wr_stb = 1'b0; rd_stb = 1'b0;
    tick();
    do_read(5'd5, rdata, rv, rh);
    check_eq("after_bypass", 32'(rdata), 32'h3C);

    do_write(5'd20, 8'h99);
    do_read(5'd20, rdata, rv, rh);
    check_eq("oor_hit",  32'(rh), 32'd0);
    check_eq("oor_data", 32'(rdata), 32'd0);
    do_read(5'd4, rdata, rv, rh);
    check_eq("oor_alias_hit", 32'(rh), 32'd0);

    // Held strobe with changing data: only the first value may land
    wr_addr = 5'd9; wr_data = 8'h42; wr_stb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      wr_data = 8'(($urandom % 255) + 1) ^ 8'h42;
    end
    wr_stb = 1'b0;
    tick();
    do_read(5'd9, rdata, rv, rh);
    check_eq("held_one_write", 32'(rdata), 32'h42);

    for (int i = 0; i < 400; i++) begin
      wr_stb  = 1'($urandom);
      rd_stb  = 1'($urandom);
      wr_addr = 5'($urandom_range(0, 19));
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 19));
      wr_data = 8'($urandom);
      tick();
    end
    wr_stb = 1'b0; rd_stb = 1'b0;
    tick();
    do_write(5'd7, 8'h5A);

    // Reset asserted in a read-edge cycle
    rd_addr = 5'd7; rd_stb = 1'b1; rst_n = 1'b0;
    tick();
    check_eq("rst_mid_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_mid_busy",  32'(busy),     32'd1);
    rd_stb = 1'b0; rst_n = 1'b1;
    n_busy = 0;
    while (busy && n_busy < 40) begin
      wr_addr = 5'd1; wr_data = 8'hEE;
      wr_stb  = (n_busy == 4);
      n_busy++;
      tick();
    end
    wr_stb = 1'b0;
    check_eq("clear2_len", 32'(n_busy), 32'd16);
    tick();
    do_read(5'd7, rdata, rv, rh);
    check_eq("post_rst_hit7", 32'(rh), 32'd0);
    do_read(5'd1, rdata, rv, rh);
    check_eq("clear_edge_hit1", 32'(rh), 32'd0);
    check_eq("clear_edge_data1", 32'(rdata), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
